// File: rtl/cpu_defs.sv
// Shared CPU pipeline definitions: the execute payload plus the sizing
// constants for the delayed-execution scheduler.
package cpu_defs;

  typedef struct packed {
    logic [5:0]  tag;
    logic [3:0]  alu_op;
    logic [31:0] operand;
  } pipeline_exec_t;

  localparam int DELAYED_SCHED_DEPTH = 4;
  localparam int DELAYED_SCHED_CNT_W = $clog2(DELAYED_SCHED_DEPTH) + 1;

  typedef logic [DELAYED_SCHED_CNT_W-1:0] delayed_sched_cnt_t;

endpackage

// File: rtl/delayed_exec_sched_if.sv
// Issue-side and delayed-ALU-side signals of the delayed-execution scheduler.
// The master modport is the pipeline around the scheduler; the slave is the scheduler.
interface delayed_exec_sched_if
  import cpu_defs::*;
#(
  parameter int DEPTH = DELAYED_SCHED_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 flush;
  logic [1:0]           in_valid;
  pipeline_exec_t [1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  pipeline_exec_t       out_data;
  logic                 out_ready;
  logic [CNT_W-1:0]     occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/delayed_sched_ram.sv
// Entry storage for the delayed-execution scheduler: two write ports,
// one asynchronous read port. Pointer logic never lets both ports hit one entry.
module delayed_sched_ram
  import cpu_defs::*;
#(
  parameter  int DEPTH = DELAYED_SCHED_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [PTR_W-1:0] waddr0,
  input  pipeline_exec_t   wdata0,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr1,
  input  pipeline_exec_t   wdata1,
  input  logic [PTR_W-1:0] raddr,
  output pipeline_exec_t   rdata
);

  pipeline_exec_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/delayed_exec_sched.sv
// In-order buffer between both issue lanes and the shared delayed ALU.
// Define DELAYED_SCHED_BYPASS_EN to pass the oldest lane straight through an empty buffer.
module delayed_exec_sched
  import cpu_defs::*;
#(
  parameter int DEPTH = DELAYED_SCHED_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  delayed_exec_sched_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] n_push;
  logic [1:0]       wr_valid;
  logic             accept, pop, we0, we1;
  pipeline_exec_t   wdata0, wdata1, rd_data;

  // Acceptance looks only at registered occupancy, so it never waits on the ALU stall.
  assign bus.in_ready = (count <= CNT_W'(DEPTH - 2));
  assign accept       = bus.in_ready & ~bus.flush;
  assign pop          = (count != '0) & bus.out_ready & ~bus.flush;

`ifdef DELAYED_SCHED_BYPASS_EN
  logic           bypass_act, bypass_take;
  pipeline_exec_t bypass_data;

  assign bypass_act  = (count == '0) & ~bus.flush & (|bus.in_valid);
  assign bypass_take = bypass_act & bus.out_ready;
  assign bypass_data = bus.in_valid[0] ? bus.in_data[0] : bus.in_data[1];

  // The entry handed straight to the ALU is not written.
  always_comb begin
    wr_valid = bus.in_valid;
    if (bypass_take) begin
      if (bus.in_valid[0]) wr_valid[0] = 1'b0;
      else                 wr_valid[1] = 1'b0;
    end
  end

  assign bus.out_valid = (count != '0) | bypass_act;
  assign bus.out_data  = (count != '0) ? rd_data : (bypass_act ? bypass_data : '0);
`else
  assign wr_valid      = bus.in_valid;
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = (count != '0) ? rd_data : '0;
`endif

  // Port 0 always takes the oldest surviving lane, which compacts a lone lane 1 into tail.
  assign we0    = accept & (|wr_valid);
  assign we1    = accept & (&wr_valid);
  assign wdata0 = wr_valid[0] ? bus.in_data[0] : bus.in_data[1];
  assign wdata1 = bus.in_data[1];
  assign n_push = CNT_W'(we0) + CNT_W'(we1);

  delayed_sched_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (tail),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (tail + PTR_W'(1)),
    .wdata1 (wdata1),
    .raddr  (head),
    .rdata  (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count + n_push - CNT_W'(pop);
    end
  end

  assign bus.occupancy = count;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !bus.in_ready |-> !(we0 | we1));
  a_count_bounded: assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(DEPTH));

endmodule
